parity_frame_rx: RTL and testbench
==================================

// Module: parity_frame_rx
// PURPOSE
//   Serial frame receiver and parity checker: the checking end of the XNOR-based parity generator path.
//   Deserialises start/data/parity/stop frames from a single-wire line (idle high) and checks parity with
//   an XOR/XNOR accumulator. Delivers the word with parity and framing status flags.
//   Sits between the line input pin and the downstream word consumer.
// PARAMETERS
//   DATA_W        8    data bits per frame, sent LSB first (1..16)
//   CLKS_PER_BIT  16   clk cycles per bit period (>=4, even)
//   ODD           0    0 = even parity, 1 = odd parity
// PORTS
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   rx        in   1       serial line, idle = 1
//   data_out  out  DATA_W  last received word, held until the next valid
//   valid     out  1       1-cycle pulse: data_out, par_err and frm_err are updated
//   par_err   out  1       parity mismatch on the last frame, held
//   frm_err   out  1       stop bit sampled 0 on the last frame, held
//   busy      out  1       1 whenever the FSM is not in IDLE
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE; data_out=0, valid=0, par_err=0, frm_err=0, busy=0.
//     Bit counter, baud counter, shift register and accumulator are cleared.
//     Reset is honoured mid-frame and the partial frame is discarded.
//   - rx_s is the sampled line value: rx itself, or the synchronised rx (see CONFIGURATION).
//   - FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
//   - IDLE: when rx_s=0 -> START; baud counter = CLKS_PER_BIT/2-1.
//   - START: at baud count 0 (mid start bit), sample rx_s.
//     rx_s=1 -> IDLE (glitch, no valid).
//     rx_s=0 -> DATA; baud counter = CLKS_PER_BIT-1; acc=ODD; bit counter=0.
//   - DATA: at each baud count 0, shift rx_s into the MSB of the shift register (LSB-first line order).
//     acc <= acc ^ rx_s. After DATA_W samples -> PARITY.
//   - PARITY: at mid-bit, perr <= acc ^ rx_s, so an error exists when the total ones count breaks the
//     even/odd rule. Then -> STOP.
//   - STOP: at mid-bit, sample rx_s. The following cycle: valid=1, data_out=shift register, par_err=perr,
//     frm_err=~rx_s. The frame is always delivered, even when a flag is set.
//     rx_s=1 -> IDLE. rx_s=0 -> BREAK.
//   - BREAK: wait for rx_s=1 -> IDLE. A low line is never taken as a new start bit in this state.
//   - Latency: valid asserts (CLKS_PER_BIT/2 + (DATA_W+2)*CLKS_PER_BIT + 1) cycles after the clk edge
//     at which rx_s is first seen 0 in IDLE.
//   - valid is never high for 2 consecutive cycles. The next start bit is accepted in the cycle after
//     return to IDLE.
//   - rx_s toggling mid-bit is ignored; only the mid-bit sample counts.
// CONFIGURATION
//   RX_SYNC_EN defined:
//     - rx passes through a 2-flop synchroniser, reset to 1, before the FSM. rx_s = synchronised rx.
//     - All FSM timing shifts by +2 cycles.
//   RX_SYNC_EN undefined:
//     - rx_s = rx directly. rx must already be synchronous to clk.
// TESTING  (DATA_W=8, CLKS_PER_BIT=4, ODD=0 unless noted; bits at 4-cycle spacing)
//   1. Frame 0xA5, parity 0, stop 1 -> one valid pulse; data_out=0xA5, par_err=0, frm_err=0, busy drops.
//   2. Frame 0x01, parity 0 -> valid; data_out=0x01, par_err=1, frm_err=0.
//   3. Frame 0x3C, parity 0, stop 0, line held low 20 cycles -> valid with frm_err=1; busy stays 1
//      until rx=1; then a 0x55 frame is received clean.
//   4. rx low for 1 cycle only (start glitch) -> no valid; busy returns to 0 within CLKS_PER_BIT/2+1 cycles.
//   5. rst_n pulsed low mid-DATA of a 0xFF frame -> all outputs 0 immediately; the next frame 0x3C is
//      received with no flags set.
//   6. ODD=1: frame 0x00 with parity 1 -> par_err=0. Same frame with parity 0 -> par_err=1.

Source files
------------

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver with parity and framing checks.
// Takes start/data/parity/stop frames from an idle-high line, LSB first.
// Each bit is sampled once, in the middle of its bit period. Parity is
// checked with an XOR accumulator that is seeded with ODD.
// Optional build macro: RX_SYNC_EN. When it is defined, rx passes through a
// 2-flop synchroniser (reset to 1) before the FSM. This adds 2 cycles to all
// FSM timing. When it is undefined, rx must already be synchronous to clk.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | line idle, waiting for a low level (start bit)
// START  | counting to the middle of the start bit to confirm it
// DATA   | sampling DATA_W data bits, LSB first, into the shift register
// PARITY | sampling the parity bit and latching the parity check result
// STOP   | sampling the stop bit, then delivering the word on the next cycle
// BREAK  | stop bit was low; waiting for the line to return high

module parity_frame_rx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int ODD          = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              par_err,
   output logic              frm_err,
   output logic              busy
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = ($clog2(DATA_W + 1) < 1) ? 1 : $clog2(DATA_W + 1);

   localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
   localparam logic              ODD_BIT   = (ODD != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   state_t             state_q;
   logic [BAUD_W-1:0]  baud_q;
   logic [BIT_W-1:0]   bit_cnt_q;
   logic [DATA_W-1:0]  shift_q;
   logic [DATA_W-1:0]  shift_d;
   logic               acc_q;
   logic               perr_q;
   logic               stop_q;
   logic               deliver_q;
   logic [DATA_W-1:0]  data_q;
   logic               valid_q;
   logic               par_err_q;
   logic               frm_err_q;
   logic               rx_s;

`ifdef RX_SYNC_EN
   logic [1:0] sync_q;

   // Two-flop synchroniser for the asynchronous line input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rx_s = sync_q[1];
`else
   assign rx_s = rx;
`endif

   // The line arrives LSB first, so each new bit enters at the MSB.
   always_comb begin
      shift_d             = shift_q >> 1;
      shift_d[DATA_W-1]   = rx_s;
   end

   // Frame FSM: mid-bit sampling, parity accumulation, and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         acc_q     <= 1'b0;
         perr_q    <= 1'b0;
         stop_q    <= 1'b0;
         deliver_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q <= START;
                  baud_q  <= BAUD_HALF;
               end
            end
            START: begin
               if (baud_q == '0) begin
                  if (rx_s) begin
                     state_q <= IDLE;
                  end else begin
                     state_q   <= DATA;
                     baud_q    <= BAUD_FULL;
                     acc_q     <= ODD_BIT;
                     bit_cnt_q <= '0;
                  end
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
            DATA: begin
               if (baud_q == '0) begin
                  shift_q <= shift_d;
                  acc_q   <= acc_q ^ rx_s;
                  baud_q  <= BAUD_FULL;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= PARITY;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                  end
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
            PARITY: begin
               if (baud_q == '0) begin
                  perr_q  <= acc_q ^ rx_s;
                  baud_q  <= BAUD_FULL;
                  state_q <= STOP;
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
            STOP: begin
               // Sample the stop bit first. Deliver on the next cycle, so that
               // valid lands one cycle after the stop-bit sample.
               if (deliver_q) begin
                  deliver_q <= 1'b0;
                  valid_q   <= 1'b1;
                  data_q    <= shift_q;
                  par_err_q <= perr_q;
                  frm_err_q <= ~stop_q;
                  state_q   <= stop_q ? IDLE : BREAK;
               end else if (baud_q == '0) begin
                  stop_q    <= rx_s;
                  deliver_q <= 1'b1;
               end else begin
                  baud_q <= baud_q - BAUD_W'(1);
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign data_out = data_q;
   assign valid    = valid_q;
   assign par_err  = par_err_q;
   assign frm_err  = frm_err_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Testbench for parity_frame_rx. Two instances (even and odd parity) share
// one line. A queue of sent frames is the reference; expected flags come
// from a ones count over the data and parity bits.
module tb_parity_frame_rx;

   localparam int DATA_W = 8;
   localparam int CPB    = 4;
`ifdef RX_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   localparam int LAT = CPB / 2 + (DATA_W + 2) * CPB + 1;

   logic              clk;
   logic              rst_n;
   logic              rx;
   logic [DATA_W-1:0] data_e, data_o;
   logic              valid_e, valid_o;
   logic              perr_e, perr_o;
   logic              ferr_e, ferr_o;
   logic              busy_e, busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              par;
      logic              stop;
      int                due;
   } frame_t;

   frame_t exp_q[$];
   logic   prev_v = 1'b0;

   parity_frame_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .ODD(0)) dut_even (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .data_out(data_e), .valid(valid_e), .par_err(perr_e),
      .frm_err(ferr_e), .busy(busy_e)
   );

   parity_frame_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .ODD(1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .data_out(data_o), .valid(valid_o), .par_err(perr_o),
      .frm_err(ferr_o), .busy(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one frame (start, data LSB first, parity, stop). With glitch set,
   // the first cycle of some data and parity bits is inverted, well away
   // from the mid-bit sample.
   task automatic send_frame(input logic [DATA_W-1:0] d, input logic p,
                             input logic s, input logic glitch);
      logic [DATA_W+2:0] seq;
      frame_t f;
      seq    = {s, p, d, 1'b0};
      f.data = d;
      f.par  = p;
      f.stop = s;
      f.due  = cyc + 1 + LAT + SYNC_LAT;
      exp_q.push_back(f);
      for (int i = 0; i < DATA_W + 3; i++) begin
         for (int c = 0; c < CPB; c++) begin
            if (glitch && i >= 1 && i <= DATA_W + 1 && c == 0 && $urandom_range(1, 0) == 1)
               rx = ~seq[i];
            else
               rx = seq[i];
            tick(1);
         end
      end
   endtask

   function automatic logic even_par(input logic [DATA_W-1:0] d);
      return logic'($countones(d) % 2);
   endfunction

   // Scoreboard: every valid pulse is matched against the oldest sent frame.
   always @(negedge clk) begin
      if (valid_e) begin
         frame_t e;
         int ones;
         chk("valid_b2b", {31'b0, prev_v}, 32'd0);
         chk("odd_valid", {31'b0, valid_o}, 32'd1);
         if (exp_q.size() == 0) begin
            chk("unexp_valid", 32'd1, 32'd0);
         end else begin
            e    = exp_q.pop_front();
            ones = $countones(e.data) + int'(e.par);
            chk("latency",  cyc, e.due);
            chk("data_e",   {24'b0, data_e}, {24'b0, e.data});
            chk("data_o",   {24'b0, data_o}, {24'b0, e.data});
            chk("perr_e",   {31'b0, perr_e}, (ones % 2 != 0) ? 32'd1 : 32'd0);
            chk("perr_o",   {31'b0, perr_o}, (ones % 2 == 0) ? 32'd1 : 32'd0);
            chk("ferr_e",   {31'b0, ferr_e}, e.stop ? 32'd0 : 32'd1);
            chk("ferr_o",   {31'b0, ferr_o}, e.stop ? 32'd0 : 32'd1);
         end
      end else if (valid_o) begin
         chk("odd_valid_alone", 32'd1, 32'd0);
      end
      prev_v = valid_e;
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"},  {24'b0, data_e} | {24'b0, data_o}, 32'd0);
      chk({tag, "_valid"}, {31'b0, valid_e | valid_o}, 32'd0);
      chk({tag, "_perr"},  {31'b0, perr_e | perr_o}, 32'd0);
      chk({tag, "_ferr"},  {31'b0, ferr_e | ferr_o}, 32'd0);
      chk({tag, "_busy"},  {31'b0, busy_e | busy_o}, 32'd0);
   endtask

   task automatic settle_idle(input string tag);
      tick(SYNC_LAT + 2);
      chk(tag, {31'b0, busy_e}, 32'd0);
   endtask

   initial begin
      logic [DATA_W-1:0] d;
      logic              p;
      logic              s;
      int                hold;
      int                waited;

      rst_n = 1'b0;
      rx    = 1'b1;
      #12;
      chk_all_zero("reset");
      tick(1);
      rst_n = 1'b1;
      tick(3);

      // Clean frame.
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
      settle_idle("busy_after_A5");

      // Parity error on the even instance.
      send_frame(8'h01, 1'b0, 1'b1, 1'b0);
      settle_idle("busy_after_01");

      // Low stop bit, line held low: break until the line returns high.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      rx = 1'b0;
      tick(20);
      chk("busy_in_break", {31'b0, busy_e}, 32'd1);
      rx = 1'b1;
      tick(1 + SYNC_LAT);
      chk("busy_break_exit", {31'b0, busy_e}, 32'd0);
      send_frame(8'h55, 1'b0, 1'b1, 1'b0);
      settle_idle("busy_after_55");

      // Start-bit glitch: line low for one cycle only.
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(SYNC_LAT);
      chk("glitch_busy", {31'b0, busy_e}, 32'd1);
      tick(CPB / 2 + 1);
      chk("glitch_idle", {31'b0, busy_e}, 32'd0);

      // Reset in the middle of a 0xFF frame.
      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(3 * CPB);
      chk("busy_mid_data", {31'b0, busy_e}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      tick(2);
      rst_n = 1'b1;
      tick(2);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      settle_idle("busy_after_rst_3C");

      // Odd-parity cases (the odd instance sees the same line).
      send_frame(8'h00, 1'b1, 1'b1, 1'b0);
      settle_idle("busy_after_00p1");
      send_frame(8'h00, 1'b0, 1'b1, 1'b0);
      settle_idle("busy_after_00p0");

      // Random frames: mostly good parity, occasional bad parity or a low
      // stop bit, random idle gaps (including back-to-back), and mid-bit
      // glitches.
      for (int n = 0; n < 40; n++) begin
         d = DATA_W'($urandom);
         p = even_par(d);
         if ($urandom_range(3, 0) == 0) p = ~p;
         s = ($urandom_range(7, 0) != 0);
         send_frame(d, p, s, logic'($urandom_range(1, 0)));
         if (!s) begin
            hold = $urandom_range(12, 4);
            rx = 1'b0;
            tick(hold);
            chk("rand_break_busy", {31'b0, busy_e}, 32'd1);
            rx = 1'b1;
            tick(1 + SYNC_LAT);
         end
         tick($urandom_range(3, 0) == 0 ? 0 : $urandom_range(5, 1) + SYNC_LAT);
      end

      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         tick(1);
         waited++;
      end
      chk("drain", exp_q.size(), 32'd0);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
